// File: rtl/operand_dispatch_buffer_if.sv
// Handshake bundle for operand_dispatch_buffer: one upstream operand port
// and NCH show-ahead channel ports, plus the flush control and drop status.
interface operand_dispatch_buffer_if #(
  parameter int WIDTH = 32,
  parameter int NCH   = 3,
  parameter int DEPTH = 4,
  parameter int SEL_W = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [SEL_W-1:0]     in_sel;
  logic [WIDTH-1:0]     in_data;
  logic [NCH-1:0]       ch_valid;
  logic [NCH-1:0]       ch_ready;
  logic [NCH*WIDTH-1:0] ch_data;
  logic [NCH*CW-1:0]    ch_count;
  logic                 sel_err;
  logic [7:0]           drop_cnt;

  modport master (
    output flush, in_valid, in_sel, in_data, ch_ready,
    input  in_ready, ch_valid, ch_data, ch_count, sel_err, drop_cnt
  );

  modport slave (
    input  flush, in_valid, in_sel, in_data, ch_ready,
    output in_ready, ch_valid, ch_data, ch_count, sel_err, drop_cnt
  );
endinterface

// File: rtl/operand_dispatch_buffer.sv
// Routes operands by in_sel into NCH independent show-ahead FIFOs; illegal
// selects are dropped, flagged for one cycle and counted (saturating).
module operand_dispatch_buffer #(
  parameter int WIDTH = 32,
  parameter int NCH   = 3,
  parameter int DEPTH = 4,
  parameter int SEL_W = 2
) (
  input logic                     clk,
  input logic                     rst,
  operand_dispatch_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [SEL_W:0] NCH_EXT = (SEL_W + 1)'(NCH);

  logic [NCH-1:0] full;
  logic           in_ready_c;
  logic           illegal;
  logic           sel_err_q, sel_err_d;
  logic [7:0]     drop_cnt_q, drop_cnt_d;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
      logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
      logic [CW-1:0]    count_q, count_d;
      logic [WIDTH-1:0] mem_q [DEPTH];
      logic             push, pop;

      assign full[gi] = (count_q == CW'(DEPTH));
      // Acceptance never looks at ch_ready, so a full channel cannot pass through.
      assign push = bus.in_valid & ~bus.flush & (bus.in_sel == SEL_W'(gi)) & ~full[gi];
      assign pop  = (count_q != '0) & bus.ch_ready[gi] & ~bus.flush;

      always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
        end else begin
          if (push) wr_ptr_d = wr_ptr_q + 1'b1;
          if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
          case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
          endcase
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          count_q  <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          count_q  <= count_d;
        end
      end

      // Storage is deliberately left unreset; validity comes from count_q.
      always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.in_data;
      end

      assign bus.ch_valid[gi]             = (count_q != '0);
      assign bus.ch_data[gi*WIDTH +: WIDTH] = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
      assign bus.ch_count[gi*CW +: CW]    = count_q;
    end
  endgenerate

  always_comb begin
    in_ready_c = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (bus.in_sel == SEL_W'(i)) in_ready_c = ~full[i];
    end
  end

  assign illegal = ({1'b0, bus.in_sel} >= NCH_EXT);

  // Drops are tracked even during flush; flush only clears the channels.
  always_comb begin
    sel_err_d  = bus.in_valid & illegal;
    drop_cnt_d = drop_cnt_q;
    if (sel_err_d && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_err_q  <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      sel_err_q  <= sel_err_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.in_ready = in_ready_c;
  assign bus.sel_err  = sel_err_q;
  assign bus.drop_cnt = drop_cnt_q;
endmodule
